exc_ctrl: RTL and testbench

Exception and interrupt sequencer that drives the CP0 register file's write and data inputs. It sits between the ID/EX pipeline stages and CP0. It collects synchronous exception requests, hardware interrupt lines and ERET, and prioritises them. It then sequences the EPC/Cause/Status updates through CP0 and redirects/flushes the pipeline. When idle, it passes decoder MTC0 writes straight through to CP0.

---
 rtl/exc_ctrl.sv | 137 +++++++++++++
 tb/tb_exc_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer: prioritises EX-stage exceptions, interrupts and ERET, then drives CP0 updates and the PC redirect/flush.
// Build option: define EXC_IRQ_SYNC_EN for a 2-flop irq synchroniser; otherwise irq passes through a single register stage.
module exc_ctrl #(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_0080,
  parameter int          IRQ_W        = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pause,
  input  logic [2:0]       mtc0_wen,
  input  logic             exc_syscall,
  input  logic             exc_break,
  input  logic             exc_ri,
  input  logic             exc_ov,
  input  logic             eret,
  input  logic [31:0]      exc_pc,
  input  logic [IRQ_W-1:0] irq,
  input  logic [31:0]      status_out,
  input  logic [31:0]      epc_out,
  output logic [2:0]       cp0_wen,
  output logic             id_cp0_in_sel,
  output logic             status_shift_sel,
  output logic [31:0]      cause_in,
  output logic [31:0]      epc_in,
  output logic             pc_redirect,
  output logic [31:0]      pc_target,
  output logic             flush,
  output logic             exc_busy
);

  // state    | meaning
  // IDLE     | MTC0 passthrough, sample requests
  // WRITE    | EPC/Cause write and Status push in CP0
  // REDIRECT | jump to handler, flush pipeline
  // ERET     | Status pop, jump to EPC, flush pipeline
  typedef enum logic [1:0] {IDLE, WRITE, REDIRECT, ERET} state_t;

  state_t      state;
  logic [IRQ_W-1:0] irq_s;
  logic [2:0]  cp0_wen_q;
  logic [31:0] epc_q;
  logic [31:0] cause_q;
  logic        exc_take;
  logic [4:0]  exccode;
  logic        unused_status;

  assign unused_status = ^status_out[31:1];

`ifdef EXC_IRQ_SYNC_EN
  logic [IRQ_W-1:0] irq_meta;
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_meta <= '0;
      irq_s    <= '0;
    end else begin
      irq_meta <= irq;
      irq_s    <= irq_meta;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset) irq_s <= '0;
    else       irq_s <= irq;
  end
`endif

  always_comb begin
    exc_take = 1'b1;
    exccode  = 5'd0;
    if (exc_ri)                               exccode = 5'd10;
    else if (exc_ov)                          exccode = 5'd12;
    else if (exc_syscall)                     exccode = 5'd8;
    else if (exc_break)                       exccode = 5'd9;
    else if ((irq_s != '0) && status_out[0])  exccode = 5'd0;
    else                                      exc_take = 1'b0;
  end

  // MTC0 writes reach CP0 combinationally only while idle
  assign cp0_wen  = (state == IDLE) ? mtc0_wen : cp0_wen_q;
  assign epc_in   = epc_q;
  assign cause_in = cause_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      cp0_wen_q        <= '0;
      id_cp0_in_sel    <= 1'b0;
      status_shift_sel <= 1'b0;
      pc_redirect      <= 1'b0;
      pc_target        <= '0;
      flush            <= 1'b0;
      exc_busy         <= 1'b0;
      epc_q            <= '0;
      cause_q          <= '0;
    end else if (!pause) begin
      cp0_wen_q        <= '0;
      id_cp0_in_sel    <= 1'b0;
      status_shift_sel <= 1'b0;
      pc_redirect      <= 1'b0;
      pc_target        <= '0;
      flush            <= 1'b0;
      exc_busy         <= 1'b0;
      case (state)
        IDLE: begin
          if (exc_take) begin
            epc_q         <= exc_pc;
            cause_q       <= {16'b0, irq_s[5:0], 3'b0, exccode, 2'b00};
            state         <= WRITE;
            cp0_wen_q     <= 3'b111;
            id_cp0_in_sel <= 1'b1;
            exc_busy      <= 1'b1;
          end else if (eret) begin
            state            <= ERET;
            cp0_wen_q        <= 3'b100;
            id_cp0_in_sel    <= 1'b1;
            status_shift_sel <= 1'b1;
            pc_redirect      <= 1'b1;
            pc_target        <= epc_out;
            flush            <= 1'b1;
            exc_busy         <= 1'b1;
          end
        end
        WRITE: begin
          state       <= REDIRECT;
          pc_redirect <= 1'b1;
          pc_target   <= HANDLER_ADDR;
          flush       <= 1'b1;
          exc_busy    <= 1'b1;
        end
        REDIRECT: state <= IDLE;
        ERET:     state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// Scoreboard bench for exc_ctrl: stimulus queues expected CP0/redirect vectors, a negedge monitor pops and compares them.
module tb_exc_ctrl;

`ifdef EXC_IRQ_SYNC_EN
  localparam int IRQ_LAT = 3;
`else
  localparam int IRQ_LAT = 2;
`endif

  typedef struct packed {
    logic [2:0]  wen;
    logic        sel;
    logic        shift;
    logic [31:0] epc;
    logic [31:0] cause;
    logic        redirect;
    logic [31:0] target;
    logic        flush;
    logic        busy;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, pause, exc_syscall, exc_break, exc_ri, exc_ov, eret;
  logic [2:0]  mtc0_wen;
  logic [31:0] exc_pc, status_out, epc_out;
  logic [5:0]  irq;
  logic [2:0]  cp0_wen;
  logic        id_cp0_in_sel, status_shift_sel, pc_redirect, flush, exc_busy;
  logic [31:0] cause_in, epc_in, pc_target;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t q[$];
  string names[$];

  exc_ctrl dut (
    .clk(clk), .reset(reset), .pause(pause), .mtc0_wen(mtc0_wen),
    .exc_syscall(exc_syscall), .exc_break(exc_break), .exc_ri(exc_ri), .exc_ov(exc_ov),
    .eret(eret), .exc_pc(exc_pc), .irq(irq), .status_out(status_out), .epc_out(epc_out),
    .cp0_wen(cp0_wen), .id_cp0_in_sel(id_cp0_in_sel), .status_shift_sel(status_shift_sel),
    .cause_in(cause_in), .epc_in(epc_in), .pc_redirect(pc_redirect), .pc_target(pc_target),
    .flush(flush), .exc_busy(exc_busy)
  );

  always #5 clk = ~clk;

  function automatic exp_t e_write(logic [31:0] epc, logic [31:0] cause);
    return '{3'b111, 1'b1, 1'b0, epc, cause, 1'b0, 32'h0, 1'b0, 1'b1};
  endfunction
  function automatic exp_t e_redir(logic [31:0] epc, logic [31:0] cause);
    return '{3'b000, 1'b0, 1'b0, epc, cause, 1'b1, 32'h80, 1'b1, 1'b1};
  endfunction
  function automatic exp_t e_eret(logic [31:0] epc, logic [31:0] cause, logic [31:0] tgt);
    return '{3'b100, 1'b1, 1'b1, epc, cause, 1'b1, tgt, 1'b1, 1'b1};
  endfunction
  function automatic exp_t e_mtc0(logic [2:0] wen, logic [31:0] epc, logic [31:0] cause);
    return '{wen, 1'b0, 1'b0, epc, cause, 1'b0, 32'h0, 1'b0, 1'b0};
  endfunction

  task automatic push(string name, exp_t e);
    q.push_back(e);
    names.push_back(name);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t act, e;
    string n;
    if (exc_busy === 1'b1 || (cp0_wen !== 3'b000 && cp0_wen !== 3'bxxx) ||
        pc_redirect === 1'b1 || flush === 1'b1) begin
      act = '{cp0_wen, id_cp0_in_sel, status_shift_sel, epc_in, cause_in,
              pc_redirect, pc_target, flush, exc_busy};
      vectors++;
      if (q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_output: got %h, expected no activity", act);
      end else begin
        e = q.pop_front();
        n = names.pop_front();
        if (act !== e) begin
          miscompares++;
          $display("FAIL %s: got %h, expected %h", n, act, e);
        end
      end
    end
  end

  initial begin
    int lat;
    reset = 1'b1; pause = 1'b0; mtc0_wen = 3'b000;
    exc_syscall = 1'b0; exc_break = 1'b0; exc_ri = 1'b0; exc_ov = 1'b0; eret = 1'b0;
    exc_pc = 32'h0; irq = 6'b0; status_out = 32'h0; epc_out = 32'h0;
    repeat (3) step();
    reset = 1'b0;

    check("rst_cp0_wen", {29'b0, cp0_wen}, 32'h0);
    check("rst_busy", {31'b0, exc_busy}, 32'h0);
    check("rst_redirect", {31'b0, pc_redirect}, 32'h0);
    check("rst_target", pc_target, 32'h0);
    check("rst_epc_in", epc_in, 32'h0);
    check("rst_cause_in", cause_in, 32'h0);
    check("rst_sel_shift_flush", {29'b0, id_cp0_in_sel, status_shift_sel, flush}, 32'h0);

    // MTC0 passthrough
    push("mtc0_pass", e_mtc0(3'b010, 32'h0, 32'h0));
    mtc0_wen = 3'b010;
    #1;
    check("mtc0_same_cycle", {29'b0, cp0_wen}, 32'h2);
    check("mtc0_in_sel", {31'b0, id_cp0_in_sel}, 32'h0);
    step();
    mtc0_wen = 3'b000;
    step();

    // syscall
    exc_pc = 32'h0000_1004; exc_syscall = 1'b1;
    push("syscall_write", e_write(32'h1004, 32'h20));
    push("syscall_redirect", e_redir(32'h1004, 32'h20));
    step();
    exc_syscall = 1'b0;
    repeat (3) step();

    // priority: ri beats ov and break
    exc_pc = 32'h0000_1008; exc_ri = 1'b1; exc_ov = 1'b1; exc_break = 1'b1;
    push("prio_write", e_write(32'h1008, 32'h28));
    push("prio_redirect", e_redir(32'h1008, 32'h28));
    step();
    exc_ri = 1'b0; exc_ov = 1'b0; exc_break = 1'b0;
    repeat (3) step();

    // interrupt, IE set
    exc_pc = 32'h0000_3000; status_out = 32'h1;
    push("irq_write", e_write(32'h3000, 32'h1000));
    push("irq_redirect", e_redir(32'h3000, 32'h1000));
    irq = 6'b000100;
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (exc_busy === 1'b1) begin
        lat = k;
        break;
      end
    end
    check("irq_latency", lat, IRQ_LAT);
    irq = 6'b0; status_out = 32'h0;
    repeat (5) step();

    // interrupt, IE clear
    irq = 6'b000100;
    repeat (6) step();
    check("irq_masked_busy", {31'b0, exc_busy}, 32'h0);
    irq = 6'b0;
    repeat (4) step();

    // ERET
    epc_out = 32'h0000_2000; eret = 1'b1;
    push("eret", e_eret(32'h3000, 32'h1000, 32'h2000));
    step();
    eret = 1'b0;
    repeat (2) step();

    // exception wins over eret
    exc_pc = 32'h0000_100C; eret = 1'b1; exc_ov = 1'b1;
    push("ov_eret_write", e_write(32'h100C, 32'h30));
    push("ov_eret_redirect", e_redir(32'h100C, 32'h30));
    step();
    eret = 1'b0; exc_ov = 1'b0;
    repeat (3) step();

    // pause held three cycles in WRITE
    exc_pc = 32'h0000_1010; exc_syscall = 1'b1;
    for (int i = 0; i < 4; i++) push("pause_write_hold", e_write(32'h1010, 32'h20));
    push("pause_redirect", e_redir(32'h1010, 32'h20));
    step();
    exc_syscall = 1'b0; pause = 1'b1;
    repeat (3) step();
    pause = 1'b0;
    repeat (3) step();

    // reset asserted in WRITE
    exc_pc = 32'h0000_1014; exc_syscall = 1'b1;
    push("reset_write", e_write(32'h1014, 32'h20));
    step();
    exc_syscall = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0;
    check("reset_mid_cp0_wen", {29'b0, cp0_wen}, 32'h0);
    check("reset_mid_redirect", {31'b0, pc_redirect}, 32'h0);
    check("reset_mid_busy", {31'b0, exc_busy}, 32'h0);
    check("reset_mid_cause", cause_in, 32'h0);
    repeat (4) step();

    check("queue_empty", q.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
